// File: rtl/priority_resolver.sv
// 8259A-style priority resolver: keeps the ISR and rotating priority, raises INT,
// runs the INTA acknowledge sequence and handles EOI, auto-EOI and rotation.
module priority_resolver #(
  parameter int INTA_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] irq,
  input  logic       intaPulse,
  input  logic       eoiNonSpecific,
  input  logic       eoiSpecific,
  input  logic [2:0] eoiLevel,
  input  logic       rotateOnEoi,
  input  logic       setPriority,
  input  logic       autoEoi,
  input  logic [4:0] vectorBase,
  output logic       intOut,
  output logic [7:0] vectorOut,
  output logic       vectorValid,
  output logic [7:0] isr,
  output logic [7:0] irrClear
);

  typedef enum logic {IDLE, WAIT2} state_t;

  localparam bit SinglePulse = (INTA_CYCLES == 1);

  state_t     state, nextState;
  logic [2:0] lowestPri, nextLowest;
  logic [2:0] winnerReg;
  logic       spuriousReg;
  logic [7:0] isrAfterEoi, isrNext;
  logic [3:0] eoiTop, isrTopAfter, reqTop;
  logic       qualify, firstPulse, vectorStep, intNext;
  logic [2:0] winnerNow, stepWinner;
  logic       spuriousNow, stepSpurious;

  // Returns {found, level} of the highest-priority set bit; rank 0 sits just above lowestPri.
  function automatic logic [3:0] topOf(input logic [7:0] vec, input logic [2:0] lp);
    logic [2:0] lvl;
    topOf = 4'b0;
    for (int r = 7; r >= 0; r--) begin
      lvl = lp + 3'(r) + 3'd1;
      if (vec[lvl]) topOf = {1'b1, lvl};
    end
  endfunction

  function automatic logic [2:0] rankOf(input logic [2:0] level, input logic [2:0] lp);
    rankOf = level - lp - 3'd1;
  endfunction

  always_comb begin
    isrAfterEoi = isr;
    nextLowest  = lowestPri;
    eoiTop      = topOf(isr, lowestPri);
    if (eoiNonSpecific && eoiTop[3]) begin
      isrAfterEoi[eoiTop[2:0]] = 1'b0;
      if (rotateOnEoi) nextLowest = eoiTop[2:0];
    end
    if (eoiSpecific) begin
      isrAfterEoi[eoiLevel] = 1'b0;
      if (rotateOnEoi) nextLowest = eoiLevel;
    end

    // Winner selection sees the ISR after this cycle's EOI, so an EOI can unblock a same-cycle ack.
    isrTopAfter = topOf(isrAfterEoi, lowestPri);
    reqTop      = topOf(irq, lowestPri);
    qualify     = reqTop[3] && (!isrTopAfter[3] ||
                  (rankOf(reqTop[2:0], lowestPri) < rankOf(isrTopAfter[2:0], lowestPri)));

    firstPulse   = intaPulse && (state == IDLE);
    winnerNow    = qualify ? reqTop[2:0] : 3'd7;
    spuriousNow  = !qualify;
    vectorStep   = intaPulse && ((state == WAIT2) || SinglePulse);
    stepWinner   = (state == WAIT2) ? winnerReg : winnerNow;
    stepSpurious = (state == WAIT2) ? spuriousReg : spuriousNow;

    isrNext = isrAfterEoi;
    if (vectorStep && autoEoi && !stepSpurious) begin
      isrNext[stepWinner] = 1'b0;
      if (rotateOnEoi) nextLowest = stepWinner;
    end
    if (firstPulse && !spuriousNow && !(SinglePulse && autoEoi)) isrNext[winnerNow] = 1'b1;
    if (setPriority) nextLowest = eoiLevel;

    nextState = state;
    case (state)
      IDLE:    if (firstPulse && !SinglePulse) nextState = WAIT2;
      WAIT2:   if (intaPulse) nextState = IDLE;
      default: nextState = IDLE;
    endcase

    intNext = (nextState == IDLE) && !intaPulse && qualify;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      lowestPri   <= 3'd7;
      winnerReg   <= 3'd7;
      spuriousReg <= 1'b0;
      isr         <= 8'h00;
      intOut      <= 1'b0;
      vectorOut   <= 8'h00;
      vectorValid <= 1'b0;
      irrClear    <= 8'h00;
    end else begin
      state       <= nextState;
      lowestPri   <= nextLowest;
      isr         <= isrNext;
      intOut      <= intNext;
      vectorValid <= vectorStep;
      irrClear    <= (firstPulse && !spuriousNow) ? (8'd1 << winnerNow) : 8'h00;
      if (firstPulse) begin
        winnerReg   <= winnerNow;
        spuriousReg <= spuriousNow;
      end
      if (vectorStep) vectorOut <= {vectorBase, stepWinner};
    end
  end

endmodule

// File: tb/tb_priority_resolver.sv
// Directed self-checking bench for priority_resolver (8086 two-pulse mode).
module tb_priority_resolver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] irq;
  logic       intaPulse, eoiNonSpecific, eoiSpecific, rotateOnEoi, setPriority, autoEoi;
  logic [2:0] eoiLevel;
  logic [4:0] vectorBase;
  logic       intOut, vectorValid;
  logic [7:0] vectorOut, isr, irrClear;

  int checkCount = 0;
  int passCount  = 0;

  priority_resolver #(.INTA_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .irq(irq), .intaPulse(intaPulse),
    .eoiNonSpecific(eoiNonSpecific), .eoiSpecific(eoiSpecific), .eoiLevel(eoiLevel),
    .rotateOnEoi(rotateOnEoi), .setPriority(setPriority), .autoEoi(autoEoi),
    .vectorBase(vectorBase), .intOut(intOut), .vectorOut(vectorOut),
    .vectorValid(vectorValid), .isr(isr), .irrClear(irrClear)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  // Advance cycles; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseInta();
    intaPulse = 1'b1;
    applyStimulus(1);
    intaPulse = 1'b0;
  endtask

  task automatic pulseEoi(input logic rotate);
    eoiNonSpecific = 1'b1;
    rotateOnEoi    = rotate;
    applyStimulus(1);
    eoiNonSpecific = 1'b0;
    rotateOnEoi    = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; irq = 8'h00; intaPulse = 1'b0; eoiNonSpecific = 1'b0;
    eoiSpecific = 1'b0; eoiLevel = 3'd0; rotateOnEoi = 1'b0; setPriority = 1'b0;
    autoEoi = 1'b0; vectorBase = 5'h01;
    applyStimulus(2);
    checkOutput("reset intOut", {7'b0, intOut}, 8'h00);
    checkOutput("reset isr", isr, 8'h00);
    checkOutput("reset vectorValid", {7'b0, vectorValid}, 8'h00);
    reset_n = 1'b1;
    applyStimulus(1);
    checkOutput("idle intOut", {7'b0, intOut}, 8'h00);

    // Basic acknowledge: IR2 beats IR5 with IR0 highest.
    irq = 8'h24;
    applyStimulus(1);
    checkOutput("irq24 intOut", {7'b0, intOut}, 8'h01);
    pulseInta();
    checkOutput("ack1 irrClear", irrClear, 8'h04);
    checkOutput("ack1 isr", isr, 8'h04);
    checkOutput("ack1 intOut low", {7'b0, intOut}, 8'h00);
    irq = 8'h20;
    pulseInta();
    checkOutput("ack1 vectorOut", vectorOut, 8'h0A);
    checkOutput("ack1 vectorValid", {7'b0, vectorValid}, 8'h01);
    checkOutput("ack1 irrClear gone", irrClear, 8'h00);
    applyStimulus(1);
    checkOutput("ack1 vectorValid one cycle", {7'b0, vectorValid}, 8'h00);
    checkOutput("IR5 blocked by IR2", {7'b0, intOut}, 8'h00);

    // Nesting: lower priority blocked, higher priority interrupts.
    irq = 8'h08;
    applyStimulus(2);
    checkOutput("nest IR3 blocked", {7'b0, intOut}, 8'h00);
    irq = 8'h01;
    applyStimulus(1);
    checkOutput("nest IR0 intOut", {7'b0, intOut}, 8'h01);
    pulseInta();
    irq = 8'h00;
    pulseInta();
    checkOutput("nest isr", isr, 8'h05);
    checkOutput("nest vectorOut", vectorOut, 8'h08);

    // Non-specific EOI, then rotating EOI making IR2 lowest.
    pulseEoi(1'b0);
    checkOutput("eoi isr", isr, 8'h04);
    pulseEoi(1'b1);
    checkOutput("rot eoi isr", isr, 8'h00);
    irq = 8'h81;
    applyStimulus(1);
    checkOutput("rot intOut", {7'b0, intOut}, 8'h01);
    pulseInta();
    checkOutput("rot irrClear", irrClear, 8'h80);
    irq = 8'h01;
    pulseInta();
    checkOutput("rot vectorOut", vectorOut, 8'h0F);
    checkOutput("rot isr", isr, 8'h80);

    // Spurious acknowledge.
    irq = 8'h00;
    vectorBase = 5'h03;
    applyStimulus(1);
    pulseInta();
    checkOutput("spur irrClear", irrClear, 8'h00);
    checkOutput("spur isr", isr, 8'h80);
    pulseInta();
    checkOutput("spur vectorOut", vectorOut, 8'h1F);
    checkOutput("spur vectorValid", {7'b0, vectorValid}, 8'h01);
    vectorBase = 5'h01;
    pulseEoi(1'b0);
    checkOutput("spur eoi isr", isr, 8'h00);

    // Auto-EOI with rotation: IR4 becomes lowest, so IR5 then wins over IR4.
    autoEoi = 1'b1;
    irq = 8'h10;
    applyStimulus(1);
    pulseInta();
    checkOutput("aeoi isr set", isr, 8'h10);
    irq = 8'h00;
    rotateOnEoi = 1'b1;
    pulseInta();
    rotateOnEoi = 1'b0;
    checkOutput("aeoi isr cleared", isr, 8'h00);
    checkOutput("aeoi vectorOut", vectorOut, 8'h0C);
    irq = 8'h30;
    applyStimulus(1);
    pulseInta();
    checkOutput("aeoi rot isr", isr, 8'h20);
    irq = 8'h10;
    pulseInta();
    checkOutput("aeoi rot vectorOut", vectorOut, 8'h0D);
    checkOutput("aeoi rot isr cleared", isr, 8'h00);
    autoEoi = 1'b0;
    irq = 8'h00;

    // setPriority restores IR0 highest: IR2 beats IR5 again.
    setPriority = 1'b1;
    eoiLevel = 3'd7;
    applyStimulus(1);
    setPriority = 1'b0;
    irq = 8'h24;
    applyStimulus(1);
    pulseInta();
    irq = 8'h04;
    pulseInta();
    checkOutput("setpri vectorOut", vectorOut, 8'h0A);
    checkOutput("setpri isr", isr, 8'h04);
    applyStimulus(1);
    checkOutput("IR2 blocked by itself", {7'b0, intOut}, 8'h00);

    // Specific EOI on IR2 coincident with a new ack of IR2: set wins.
    eoiSpecific = 1'b1;
    eoiLevel = 3'd2;
    pulseInta();
    eoiSpecific = 1'b0;
    checkOutput("coinc isr", isr, 8'h04);
    checkOutput("coinc irrClear", irrClear, 8'h04);

    // Reset during WAIT2 aborts the sequence.
    irq = 8'h00;
    reset_n = 1'b0;
    #1;
    checkOutput("rst isr", isr, 8'h00);
    checkOutput("rst vectorOut", vectorOut, 8'h00);
    checkOutput("rst irrClear", irrClear, 8'h00);
    checkOutput("rst vectorValid", {7'b0, vectorValid}, 8'h00);
    checkOutput("rst intOut", {7'b0, intOut}, 8'h00);
    applyStimulus(2);
    reset_n = 1'b1;
    applyStimulus(1);
    pulseInta();
    checkOutput("post-rst no vector", {7'b0, vectorValid}, 8'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
